// File: rtl/hough_frame_ctrl.sv
// Frame sequencer for the Hough pipeline: generates FrameIn/LineIn timing and pixel fetches,
// then waits for the pipeline to drain. Optional DRAIN watchdog: HOUGH_CTRL_TIMEOUT_EN.
module hough_frame_ctrl #(
  parameter int unsigned HBLANK  = 4,
  parameter int unsigned VBLANK  = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Start,
  input  logic       Abort,
  input  logic [7:0] CfgWidth,
  input  logic [7:0] CfgHeight,
  input  logic       FrameRet,
  output logic       FrameIn,
  output logic       LineIn,
  output logic       PixelReq,
  output logic [7:0] PixelX,
  output logic [7:0] PixelY,
  output logic       Busy,
  output logic       Done,
  output logic       CfgErr,
  output logic       TimeoutErr
);

  typedef enum logic [2:0] {StIdle, StLine, StHbl, StDrain, StVbl} state_e;

  localparam logic [7:0] HblLast = 8'(HBLANK - 1);
  localparam logic [7:0] VblLast = 8'(VBLANK - 1);

  state_e     state_q, state_d;
  logic [7:0] w_q, w_d, h_q, h_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic [7:0] blk_q, blk_d;
  logic       seen_q, seen_d;
  logic       done_q, done_d;
  logic       cfg_err_q, cfg_err_d;
  logic       tmo_q, tmo_d;

`ifdef HOUGH_CTRL_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);
  logic [15:0] tcnt_q, tcnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    x_d       = x_q;
    y_d       = y_q;
    blk_d     = blk_q;
    seen_d    = seen_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    tmo_d     = 1'b0;
`ifdef HOUGH_CTRL_TIMEOUT_EN
    tcnt_d    = tcnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (Start) begin
          if (CfgWidth != 8'd0 && CfgHeight != 8'd0) begin
            w_d     = CfgWidth;
            h_d     = CfgHeight;
            x_d     = 8'd0;
            y_d     = 8'd0;
            seen_d  = 1'b0;
            state_d = StLine;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StLine: begin
        if (FrameRet) seen_d = 1'b1;
        if (x_q == w_q - 8'd1) begin
          x_d   = 8'd0;
          blk_d = 8'd0;
          if (y_q == h_q - 8'd1) begin
            y_d     = 8'd0;
            state_d = StDrain;
`ifdef HOUGH_CTRL_TIMEOUT_EN
            tcnt_d  = 16'd0;
`endif
          end else begin
            state_d = StHbl;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      StHbl: begin
        if (FrameRet) seen_d = 1'b1;
        if (blk_q == HblLast) begin
          y_d     = y_q + 8'd1;
          x_d     = 8'd0;
          state_d = StLine;
        end else begin
          blk_d = blk_q + 8'd1;
        end
      end
      StDrain: begin
        if (FrameRet) seen_d = 1'b1;
        // Pipeline has drained once FrameRet has been high and is now low again.
        if (!FrameRet && seen_q) begin
          seen_d  = 1'b0;
          blk_d   = 8'd0;
          state_d = StVbl;
        end
`ifdef HOUGH_CTRL_TIMEOUT_EN
        else if (tcnt_q == TmoLast) begin
          seen_d  = 1'b0;
          tmo_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
`endif
      end
      StVbl: begin
        if (blk_q == VblLast) begin
          blk_d   = 8'd0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          blk_d = blk_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including a Start accepted in the same cycle.
    if (Abort) begin
      state_d   = StIdle;
      w_d       = w_q;
      h_d       = h_q;
      x_d       = 8'd0;
      y_d       = 8'd0;
      blk_d     = 8'd0;
      seen_d    = 1'b0;
      done_d    = 1'b0;
      cfg_err_d = 1'b0;
      tmo_d     = 1'b0;
`ifdef HOUGH_CTRL_TIMEOUT_EN
      tcnt_d    = 16'd0;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q   <= StIdle;
      w_q       <= 8'd0;
      h_q       <= 8'd0;
      x_q       <= 8'd0;
      y_q       <= 8'd0;
      blk_q     <= 8'd0;
      seen_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      tmo_q     <= 1'b0;
`ifdef HOUGH_CTRL_TIMEOUT_EN
      tcnt_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      x_q       <= x_d;
      y_q       <= y_d;
      blk_q     <= blk_d;
      seen_q    <= seen_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      tmo_q     <= tmo_d;
`ifdef HOUGH_CTRL_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
`endif
    end
  end

  always_comb begin
    LineIn     = (state_q == StLine);
    PixelReq   = LineIn;
    FrameIn    = (state_q == StLine) || (state_q == StHbl);
    PixelX     = LineIn ? x_q : 8'd0;
    PixelY     = LineIn ? y_q : 8'd0;
    Busy       = (state_q != StIdle);
    Done       = done_q;
    CfgErr     = cfg_err_q;
`ifdef HOUGH_CTRL_TIMEOUT_EN
    TimeoutErr = tmo_q;
`else
    TimeoutErr = 1'b0;
`endif
  end

endmodule
